branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage RV32I pipeline.
- Predicts conditional branches (opcode 1100011) in IF using a table of 2-bit saturating counters and supplies the predicted next PC.
- Resolves each branch in EX and updates the table.
- Drives BEQ_WRONG_PRED and the recovery PC to the hazard unit, which performs the PC write and flush.

Parameters:
- IDX_BITS, 4, log2 of counter-table entries (16 entries).
- PC_W, 32, PC width.
- INIT_CNT, 2'b01, counter reset value (weakly not-taken).
- MISS_W, 16, width of the mispredict statistics counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PC_IF  in  PC_W  PC of the instruction in IF.
- INSTR_IF  in  32  instruction word fetched in IF.
- PRED_TAKEN  out  1  IF-stage prediction; 1 only for a branch opcode predicted taken.
- PRED_NPC  out  PC_W  predicted next PC: PC_IF+B-imm if PRED_TAKEN, else PC_IF+4.
- BR_VALID_EX  in  1  a branch is in EX this cycle (not stalled, not flushed).
- PC_EX  in  PC_W  PC of the branch in EX.
- PRED_TAKEN_EX  in  1  prediction carried down the pipeline with the branch.
- BR_TAKEN_EX  in  1  actual outcome from the ALU compare.
- BR_TARGET_EX  in  PC_W  computed branch target.
- BEQ_WRONG_PRED  out  1  misprediction in EX.
- RECOVER_PC  out  PC_W  correct next PC on misprediction.
- MISS_CNT  out  MISS_W  saturating count of mispredictions.
- BR_CNT  out  MISS_W  saturating count of resolved branches.

Behaviour:
- Reset (async, RST_N=0): all counters = INIT_CNT, history register = 0, MISS_CNT = 0, BR_CNT = 0.
- While in reset, combinational outputs follow their inputs; BEQ_WRONG_PRED is forced 0.
- Table index (IF) = PC_IF[IDX_BITS+1:2]; index (EX) = PC_EX[IDX_BITS+1:2].
- Prediction, combinational, zero latency:
  - PRED_TAKEN = (INSTR_IF[6:0]==1100011) && counter[idx_if][1].
  - B-imm = sign-extended {INSTR[31],INSTR[7],INSTR[30:25],INSTR[11:8],0}.
  - PC add wraps modulo 2^PC_W.
- Resolution, combinational:
  - BEQ_WRONG_PRED = BR_VALID_EX && (PRED_TAKEN_EX != BR_TAKEN_EX).
  - RECOVER_PC = BR_TAKEN_EX ? BR_TARGET_EX : PC_EX+4.
  - RECOVER_PC is defined every cycle; it is only meaningful when BEQ_WRONG_PRED=1.
- Update on the rising edge when BR_VALID_EX=1:
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
  - Counter states: SNT=00, WNT=01, WT=10, ST=11.
- BR_CNT increments once per BR_VALID_EX cycle; MISS_CNT increments once per BEQ_WRONG_PRED cycle. Both hold at all-ones.
- Same-index read/update in one cycle: IF reads the pre-update value. There is no bypass; the new value is visible the next cycle.
- BR_VALID_EX=0: no state change.
- A pipeline stall is expressed by the pipeline deasserting BR_VALID_EX; the predictor has no stall input.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - IDX_BITS-wide global history register GHR, shifted left with BR_TAKEN_EX on every BR_VALID_EX edge.
  - Both indices are XORed with GHR.
  - The IF index uses the current GHR.
  - The EX index uses GHR_EX, a snapshot of GHR taken at prediction time, supplied on an extra input GHR_EX[IDX_BITS-1:0].
  - On BEQ_WRONG_PRED, GHR is restored to {GHR_EX[IDX_BITS-2:0],BR_TAKEN_EX}.
  - Extra output GHR_IF gives the current GHR for pipelining.
- Undefined: no GHR, no GHR_EX/GHR_IF ports, plain bimodal indexing.

Decomposition:
- Package bp_pkg holds:
  - OP_BRANCH = 7'b1100011.
  - Counter enum typedef (SNT/WNT/WT/ST).
  - Function for the saturating counter update.
  - Function for B-immediate extraction.
- One sub-module, bp_counter_table:
  - 2^IDX_BITS x 2-bit array.
  - One async read port and one synchronous update port.
  - Async active-low reset to INIT_CNT.

Test Plan:
- Reset, INSTR_IF=beq (opcode 1100011, imm +16), PC_IF=0x100 -> PRED_TAKEN=0, PRED_NPC=0x104; MISS_CNT=0, BR_CNT=0.
- Resolve PC_EX=0x100 taken twice with PRED_TAKEN_EX=0 -> BEQ_WRONG_PRED=1 both cycles, RECOVER_PC=BR_TARGET_EX=0x110. Then IF at 0x100 gives PRED_TAKEN=1, PRED_NPC=0x110, MISS_CNT=2.
- Saturation: 5 taken updates at one index, then 1 not-taken -> counter 11 then 10; prediction stays taken. A further not-taken gives 01 -> not-taken.
- Same-cycle update and IF read of index 3 (counter 01, taken update) -> PRED_TAKEN=0 that cycle, 1 the next cycle.
- Non-branch opcode (0110011) with counter=11 -> PRED_TAKEN=0, PRED_NPC=PC_IF+4. Backward branch imm -8 at PC 0x0 -> PRED_NPC wraps to 0xFFFFFFF8.
- Assert RST_N mid-sequence with counters trained -> all outputs and counters return to their reset values immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
package bp_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // 2-bit saturating counter states
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  // Saturating increment on taken, saturating decrement on not-taken
  function automatic cnt_e cnt_update(input cnt_e c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : cnt_e'(c + 2'd1);
    end
    return (c == SNT) ? SNT : cnt_e'(c - 2'd1);
  endfunction

  // Takes {instr[31:25], instr[11:7]} and returns the 13-bit B-immediate
  function automatic logic [12:0] b_imm(input logic [11:0] bits);
    return {bits[11], bits[0], bits[10:5], bits[4:1], 1'b0};
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters: one async read port, one synchronous update port.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4,
  parameter logic [1:0]  INIT_CNT = 2'b01
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic [1:0]          o_rd_cnt,
  input  logic                i_we,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic                i_taken
);

  localparam int unsigned Entries = 2 ** IDX_BITS;

  logic [1:0] r_cnt [Entries];

  // Read returns the pre-update value; no bypass from the update port
  assign o_rd_cnt = r_cnt[i_rd_idx];

  // Counter update on a resolved branch, async reset to INIT_CNT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        r_cnt[i] <= INIT_CNT;
      end
    end else if (i_we) begin
      r_cnt[i_wr_idx] <= cnt_update(cnt_e'(r_cnt[i_wr_idx]), i_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with EX-stage resolution and mispredict statistics.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned PC_W     = 32,
  parameter logic [1:0]  INIT_CNT = 2'b01,
  parameter int unsigned MISS_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PC_W-1:0]     i_pc_if,
  input  logic [31:0]         i_instr_if,
  output logic                o_pred_taken,
  output logic [PC_W-1:0]     o_pred_npc,
  input  logic                i_br_valid_ex,
  input  logic [PC_W-1:0]     i_pc_ex,
  input  logic                i_pred_taken_ex,
  input  logic                i_br_taken_ex,
  input  logic [PC_W-1:0]     i_br_target_ex,
`ifdef BP_GSHARE_EN
  input  logic [IDX_BITS-1:0] i_ghr_ex,
  output logic [IDX_BITS-1:0] o_ghr_if,
`endif
  output logic                o_beq_wrong_pred,
  output logic [PC_W-1:0]     o_recover_pc,
  output logic [MISS_W-1:0]   o_miss_cnt,
  output logic [MISS_W-1:0]   o_br_cnt
);

  logic [IDX_BITS-1:0] w_idx_if;
  logic [IDX_BITS-1:0] w_idx_ex;
  logic [1:0]          w_rd_cnt;
  logic [12:0]         w_imm13;
  logic [PC_W-1:0]     w_imm;
  logic                w_is_branch;
  logic                w_wrong;
  logic                w_unused_instr;
  logic [MISS_W-1:0]   r_miss_cnt;
  logic [MISS_W-1:0]   r_br_cnt;

  assign w_unused_instr = ^i_instr_if[24:12];

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] r_ghr;

  assign w_idx_if = i_pc_if[IDX_BITS+1:2] ^ r_ghr;
  assign w_idx_ex = i_pc_ex[IDX_BITS+1:2] ^ i_ghr_ex;
  assign o_ghr_if = r_ghr;

  // History shifts on every resolved branch; a mispredict rebuilds it from the snapshot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ghr <= '0;
    end else if (i_br_valid_ex) begin
      if (w_wrong) begin
        r_ghr <= {i_ghr_ex[IDX_BITS-2:0], i_br_taken_ex};
      end else begin
        r_ghr <= {r_ghr[IDX_BITS-2:0], i_br_taken_ex};
      end
    end
  end
`else
  assign w_idx_if = i_pc_if[IDX_BITS+1:2];
  assign w_idx_ex = i_pc_ex[IDX_BITS+1:2];
`endif

  bp_counter_table #(
    .IDX_BITS (IDX_BITS),
    .INIT_CNT (INIT_CNT)
  ) u_table (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rd_idx (w_idx_if),
    .o_rd_cnt (w_rd_cnt),
    .i_we     (i_br_valid_ex),
    .i_wr_idx (w_idx_ex),
    .i_taken  (i_br_taken_ex)
  );

  // IF-stage prediction and next-PC, zero latency
  always_comb begin
    w_is_branch  = (i_instr_if[6:0] == OP_BRANCH);
    w_imm13      = b_imm({i_instr_if[31:25], i_instr_if[11:7]});
    w_imm        = {{(PC_W-13){w_imm13[12]}}, w_imm13};
    o_pred_taken = w_is_branch && w_rd_cnt[1];
    o_pred_npc   = i_pc_if + (o_pred_taken ? w_imm : PC_W'(4));
  end

  // EX-stage resolution; mispredict is suppressed while in reset
  always_comb begin
    w_wrong          = i_rst_n && i_br_valid_ex && (i_pred_taken_ex != i_br_taken_ex);
    o_beq_wrong_pred = w_wrong;
    o_recover_pc     = i_br_taken_ex ? i_br_target_ex : (i_pc_ex + PC_W'(4));
  end

  // Saturating branch and mispredict statistics
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (i_br_valid_ex && !(&r_br_cnt)) begin
        r_br_cnt <= r_br_cnt + MISS_W'(1);
      end
      if (w_wrong && !(&r_miss_cnt)) begin
        r_miss_cnt <= r_miss_cnt + MISS_W'(1);
      end
    end
  end

  assign o_miss_cnt = r_miss_cnt;
  assign o_br_cnt   = r_br_cnt;

endmodule
